// File: rtl/qspi_dual_slave_phy.sv
// ============================================================================
// Module   : qspi_dual_slave_phy
// Purpose  : Dual-lane SPI slave front end. Oversamples the pad chip select
//            and serial clock, deserialises two bits per rising sclk edge into
//            bytes, and (when QSPI_TX_EN is defined) serialises response bytes
//            back onto the data pads after a read command (command bit 7 set).
// Options  : QSPI_TX_EN - enables the TX state and the pad output path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qspi_dual_slave_phy #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       io_ss,
    input  logic       io_sclk,
    input  logic [1:0] io_qd_read,
    output logic [1:0] io_qd_write,
    output logic [1:0] io_qd_writeEnable,
    output logic       io_rx_valid,
    output logic [7:0] io_rx_data,
    output logic       io_rx_first,
    output logic       io_frame_end,
    output logic       io_tx_ready,
    input  logic [7:0] io_tx_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RX   = 2'd2,
        ST_TX   = 2'd3
    } state_t;

    state_t                      r_state;
    logic [SYNC_STAGES-1:0]      r_ss_sync;
    logic [SYNC_STAGES-1:0]      r_sclk_sync;
    logic [SYNC_STAGES-1:0][1:0] r_qd_sync;
    logic                        r_sclk_hist;
    logic [1:0]                  r_cnt;
    logic [5:0]                  r_rx_sr;

    logic                        w_ss;
    logic                        w_sclk;
    logic [1:0]                  w_qd;
    logic                        w_sclk_rise;
    logic [7:0]                  w_byte;
    logic                        w_byte_done;

`ifdef QSPI_TX_EN
    logic                        r_tx_ready;
    logic [7:0]                  r_tx_next;
    logic                        r_tx_pending;
    logic [7:0]                  r_tx_sr;
    logic                        r_tx_oe;
    logic                        w_sclk_fall;
`endif

    assign w_ss        = r_ss_sync[SYNC_STAGES-1];
    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_qd        = r_qd_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_hist;
    // Byte as it will look once the current dibit is shifted in.
    assign w_byte      = {r_rx_sr, w_qd};
    assign w_byte_done = (r_cnt == 2'd3);

    // Pad synchronisers plus the sclk history flop used for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ss_sync   <= '1;
            r_sclk_sync <= '0;
            r_qd_sync   <= '0;
            r_sclk_hist <= 1'b0;
        end else begin
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], io_ss};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], io_sclk};
            r_qd_sync   <= {r_qd_sync[SYNC_STAGES-2:0], io_qd_read};
            r_sclk_hist <= w_sclk;
        end
    end

`ifdef QSPI_TX_EN
    assign w_sclk_fall       = ~w_sclk & r_sclk_hist;
    assign io_tx_ready       = r_tx_ready;
    assign io_qd_write       = r_tx_sr[7:6];
    assign io_qd_writeEnable = {2{r_tx_oe}};
`else
    logic w_unused_tx;
    assign w_unused_tx       = ^io_tx_data;
    assign io_tx_ready       = 1'b0;
    assign io_qd_write       = 2'b00;
    assign io_qd_writeEnable = 2'b00;
`endif

    // Frame state machine, receive deserialiser and transmit serialiser.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 2'd0;
            r_rx_sr      <= 6'd0;
            io_rx_valid  <= 1'b0;
            io_rx_first  <= 1'b0;
            io_rx_data   <= 8'h00;
            io_frame_end <= 1'b0;
`ifdef QSPI_TX_EN
            r_tx_ready   <= 1'b0;
            r_tx_next    <= 8'h00;
            r_tx_pending <= 1'b0;
            r_tx_sr      <= 8'h00;
            r_tx_oe      <= 1'b0;
`endif
        end else begin
            io_rx_valid  <= 1'b0;
            io_rx_first  <= 1'b0;
            io_frame_end <= 1'b0;
`ifdef QSPI_TX_EN
            r_tx_ready   <= 1'b0;
            // Response byte is taken while the ready pulse is visible.
            if (r_tx_ready) begin
                r_tx_next    <= io_tx_data;
                r_tx_pending <= 1'b1;
            end
`endif
            if (r_state != ST_IDLE && w_ss) begin
                // Deselect wins over any edge in the same cycle; partial byte dropped.
                r_state      <= ST_IDLE;
                r_cnt        <= 2'd0;
                io_frame_end <= 1'b1;
`ifdef QSPI_TX_EN
                r_tx_pending <= 1'b0;
                r_tx_sr      <= 8'h00;
                r_tx_oe      <= 1'b0;
`endif
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_ss) begin
                            r_state <= ST_CMD;
                            r_cnt   <= 2'd0;
                        end
                    end
                    ST_CMD, ST_RX: begin
                        if (w_sclk_rise) begin
                            r_rx_sr <= w_byte[5:0];
                            r_cnt   <= r_cnt + 2'd1;
                            if (w_byte_done) begin
                                io_rx_valid <= 1'b1;
                                io_rx_data  <= w_byte;
                                io_rx_first <= (r_state == ST_CMD);
                                r_state     <= ST_RX;
`ifdef QSPI_TX_EN
                                if (r_state == ST_CMD && w_byte[7]) begin
                                    r_state    <= ST_TX;
                                    r_tx_ready <= 1'b1;
                                end
`endif
                            end
                        end
                    end
`ifdef QSPI_TX_EN
                    ST_TX: begin
                        if (w_sclk_rise) begin
                            r_cnt <= r_cnt + 2'd1;
                            if (w_byte_done) begin
                                r_tx_ready <= 1'b1;
                            end
                        end
                        // Host samples on rising edges, so data moves on falling edges.
                        if (w_sclk_fall) begin
                            r_tx_oe <= 1'b1;
                            if (r_tx_pending) begin
                                r_tx_sr      <= r_tx_next;
                                r_tx_pending <= 1'b0;
                            end else begin
                                r_tx_sr <= {r_tx_sr[5:0], 2'b00};
                            end
                        end
                    end
`endif
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire
